// File: rtl/arc4_ctrl.sv
// ARC4 top-level sequencer: runs init, ksa, prga in turn and owns the S memory mux.
// Optional per-phase watchdog compiled in with `define ARC4_CTRL_WATCHDOG_EN.
module arc4_ctrl #(
  parameter int WDOG_CYCLES = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  output logic        rdy,
  input  logic [23:0] key,
  output logic        done,
  output logic        err,
  output logic [23:0] key_out,
  output logic        init_en,
  output logic        ksa_en,
  output logic        prga_en,
  input  logic        init_rdy,
  input  logic        ksa_rdy,
  input  logic        prga_rdy,
  input  logic [7:0]  init_addr,
  input  logic [7:0]  ksa_addr,
  input  logic [7:0]  prga_addr,
  input  logic [7:0]  init_wrdata,
  input  logic [7:0]  ksa_wrdata,
  input  logic [7:0]  prga_wrdata,
  input  logic        init_wren,
  input  logic        ksa_wren,
  input  logic        prga_wren,
  output logic [7:0]  s_addr,
  output logic [7:0]  s_wrdata,
  output logic        s_wren
);

  typedef enum logic [3:0] {
    IDLE, INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN, DONE
`ifdef ARC4_CTRL_WATCHDOG_EN
    , ERR
`endif
  } state_t;

  // The 13-bit watchdog counter must be able to reach WDOG_CYCLES-1.
  if (WDOG_CYCLES < 2 || WDOG_CYCLES > 8192) begin : g_wdog_range
    $error("arc4_ctrl: WDOG_CYCLES out of range");
  end

  state_t      state_reg, state_next;
  logic        guard_reg;
  logic [23:0] key_out_reg;
  logic        accept;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      guard_reg   <= 1'b0;
      key_out_reg <= '0;
    end else begin
      state_reg <= state_next;
      // Sub-blocks drop rdy only the cycle after seeing en, so the first RUN cycle ignores rdy.
      guard_reg <= init_en | ksa_en | prga_en;
      if (accept) key_out_reg <= key;
    end
  end

  assign key_out = key_out_reg;

`ifdef ARC4_CTRL_WATCHDOG_EN
  localparam logic [12:0] WDOG_LAST = 13'(WDOG_CYCLES - 1);
  logic [12:0] wdog_cnt_reg, wdog_cnt_next;
  logic        in_phase;

  assign in_phase = (state_reg inside {INIT_GO, INIT_RUN, KSA_GO, KSA_RUN, PRGA_GO, PRGA_RUN});

  always_comb begin
    wdog_cnt_next = wdog_cnt_reg;
    if (state_next != state_reg && (state_next inside {INIT_GO, KSA_GO, PRGA_GO}))
      wdog_cnt_next = '0;
    else if (in_phase)
      wdog_cnt_next = wdog_cnt_reg + 13'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wdog_cnt_reg <= '0;
    else        wdog_cnt_reg <= wdog_cnt_next;
  end

  assign err = (state_reg == ERR);
`else
  assign err = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    rdy        = 1'b0;
    done       = 1'b0;
    init_en    = 1'b0;
    ksa_en     = 1'b0;
    prga_en    = 1'b0;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        rdy = 1'b1;
        if (en) begin
          accept     = 1'b1;
          state_next = INIT_GO;
        end
      end
      INIT_GO:  if (init_rdy) begin init_en = 1'b1; state_next = INIT_RUN; end
      INIT_RUN: if (!guard_reg && init_rdy) state_next = KSA_GO;
      KSA_GO:   if (ksa_rdy) begin ksa_en = 1'b1; state_next = KSA_RUN; end
      KSA_RUN:  if (!guard_reg && ksa_rdy) state_next = PRGA_GO;
      PRGA_GO:  if (prga_rdy) begin prga_en = 1'b1; state_next = PRGA_RUN; end
      PRGA_RUN: if (!guard_reg && prga_rdy) state_next = DONE;
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
`ifdef ARC4_CTRL_WATCHDOG_EN
      ERR: begin
        rdy = 1'b1;
        if (en) begin
          accept     = 1'b1;
          state_next = INIT_GO;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
`ifdef ARC4_CTRL_WATCHDOG_EN
    if (in_phase && wdog_cnt_reg == WDOG_LAST && state_next == state_reg) begin
      state_next = ERR;
      init_en    = 1'b0;
      ksa_en     = 1'b0;
      prga_en    = 1'b0;
    end
`endif
  end

  // Only the phase owner reaches the S port; everything else parks it at zero.
  always_comb begin
    s_addr   = '0;
    s_wrdata = '0;
    s_wren   = 1'b0;
    case (state_reg)
      INIT_GO, INIT_RUN: begin
        s_addr = init_addr; s_wrdata = init_wrdata; s_wren = init_wren;
      end
      KSA_GO, KSA_RUN: begin
        s_addr = ksa_addr; s_wrdata = ksa_wrdata; s_wren = ksa_wren;
      end
      PRGA_GO, PRGA_RUN: begin
        s_addr = prga_addr; s_wrdata = prga_wrdata; s_wren = prga_wren;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arc4_ctrl.sv
// Directed testbench for arc4_ctrl with simple latency models of init/ksa/prga.
module tb_arc4_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rdy, done, err;
  logic [23:0] key = '0;
  logic [23:0] key_out;
  logic        init_en, ksa_en, prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_addr = '0, ksa_addr = '0, prga_addr = '0;
  logic [7:0]  init_wrdata = '0, ksa_wrdata = '0, prga_wrdata = '0;
  logic        init_wren = 1'b0, ksa_wren = 1'b0, prga_wren = 1'b0;
  logic [7:0]  s_addr, s_wrdata;
  logic        s_wren;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  arc4_ctrl #(.WDOG_CYCLES(4096)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .rdy(rdy), .key(key), .done(done), .err(err),
    .key_out(key_out), .init_en(init_en), .ksa_en(ksa_en), .prga_en(prga_en),
    .init_rdy(init_rdy), .ksa_rdy(ksa_rdy), .prga_rdy(prga_rdy),
    .init_addr(init_addr), .ksa_addr(ksa_addr), .prga_addr(prga_addr),
    .init_wrdata(init_wrdata), .ksa_wrdata(ksa_wrdata), .prga_wrdata(prga_wrdata),
    .init_wren(init_wren), .ksa_wren(ksa_wren), .prga_wren(prga_wren),
    .s_addr(s_addr), .s_wrdata(s_wrdata), .s_wren(s_wren)
  );

  // Sub-block models: rdy drops for lat_* cycles after en is taken.
  int   lat_init = 0, lat_ksa = 0, lat_prga = 0;
  int   busy_init = 0, busy_ksa = 0, busy_prga = 0;
  logic init_hold = 1'b0, ksa_hold = 1'b0;

  always @(posedge clk) begin
    if (init_en) busy_init <= lat_init; else if (busy_init > 0) busy_init <= busy_init - 1;
    if (ksa_en)  busy_ksa  <= lat_ksa;  else if (busy_ksa > 0)  busy_ksa  <= busy_ksa - 1;
    if (prga_en) busy_prga <= lat_prga; else if (busy_prga > 0) busy_prga <= busy_prga - 1;
  end

  assign init_rdy = (busy_init == 0) && !init_hold;
  assign ksa_rdy  = (busy_ksa == 0) && !ksa_hold;
  assign prga_rdy = (busy_prga == 0);

  int n_init_en = 0, n_ksa_en = 0, n_prga_en = 0, n_done = 0;
  always @(negedge clk) begin
    if (init_en) n_init_en++;
    if (ksa_en)  n_ksa_en++;
    if (prga_en) n_prga_en++;
    if (done)    n_done++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  int t_init, t_ksa, t_prga, t_done;

  initial begin
    // Reset state
    ksa_wren = 1'b1;
    #22;
    chk("rst_rdy", rdy, 1); chk("rst_done", done, 0); chk("rst_err", err, 0);
    chk("rst_key_out", key_out, 0); chk("rst_s_wren", s_wren, 0);
    chk("rst_s_addr", s_addr, 0); chk("rst_ens", {init_en, ksa_en, prga_en}, 0);
    ksa_wren = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Op 1: latencies 256/768/40, key 000311
    lat_init = 256; lat_ksa = 768; lat_prga = 40;
    t_init = -1; t_ksa = -1; t_prga = -1; t_done = -1;
    key = 24'h000311; en = 1'b1;
    for (int i = 1; i <= 1072; i++) begin
      step();
      if (i == 1) en = 1'b0;
      if (i == 300) begin
        init_wren = 1'b1; prga_wren = 1'b1; ksa_wren = 1'b0;
        ksa_addr = 8'h5A; ksa_wrdata = 8'hC3;
      end
      #1;
      if (init_en && t_init < 0) t_init = i;
      if (ksa_en && t_ksa < 0)   t_ksa = i;
      if (prga_en && t_prga < 0) t_prga = i;
      if (done && t_done < 0)    t_done = i;
      if (i == 1)   chk("op1_rdy_low", rdy, 0);
      if (i == 300) begin
        chk("ksa_mux_wren", s_wren, 0);
        chk("ksa_mux_addr", s_addr, 8'h5A);
        chk("ksa_mux_wrdata", s_wrdata, 8'hC3);
        chk("op1_key_mid", key_out, 24'h000311);
        init_wren = 1'b0; prga_wren = 1'b0; ksa_addr = '0; ksa_wrdata = '0;
      end
      if (i == 1072) begin
        chk("op1_rdy_back", rdy, 1);
        chk("op1_done_low", done, 0);
        chk("op1_key_end", key_out, 24'h000311);
      end
    end
    chk("op1_t_init_en", t_init, 1);
    chk("op1_t_ksa_en", t_ksa, 259);
    chk("op1_t_prga_en", t_prga, 1029);
    chk("op1_t_done", t_done, 1071);
    chk("op1_n_init_en", n_init_en, 1);
    chk("op1_n_ksa_en", n_ksa_en, 1);
    chk("op1_n_prga_en", n_prga_en, 1);
    chk("op1_n_done", n_done, 1);
    $display("op1 key=%06h done_cycle=%0d", 24'h000311, t_done);

    // Op 2, back-to-back: en in first IDLE cycle, ksa_rdy held low 5 cycles, en during PRGA_RUN
    n_init_en = 0; n_ksa_en = 0; n_prga_en = 0; n_done = 0;
    lat_init = 3; lat_ksa = 4; lat_prga = 5; ksa_hold = 1'b1;
    key = 24'hABCDEF; en = 1'b1;
    for (int i = 1; i <= 25; i++) begin
      step();
      if (i == 1)  en = 1'b0;
      if (i == 11) ksa_hold = 1'b0;
      if (i == 19) begin en = 1'b1; key = 24'hFFFFFF; end
      if (i == 20) en = 1'b0;
      #1;
      if (i == 1) chk("op2_accepted", init_en, 1);
      if (i >= 6 && i <= 10) chk("op2_ksa_hold_en", ksa_en, 0);
      if (i == 10) chk("op2_ksa_hold_rdy", rdy, 0);
      if (i == 11) chk("op2_ksa_en_rise", ksa_en, 1);
      if (i == 20) chk("op2_key_ignored", key_out, 24'hABCDEF);
      if (i == 23) chk("op2_done_early", done, 0);
      if (i == 24) chk("op2_done", done, 1);
      if (i == 25) begin
        chk("op2_rdy_back", rdy, 1);
        chk("op2_key_end", key_out, 24'hABCDEF);
      end
    end
    chk("op2_n_ksa_en", n_ksa_en, 1);
    chk("op2_n_done", n_done, 1);
    $display("op2 key=%06h done_count=%0d", 24'hABCDEF, n_done);

    // Op 3: reset in the middle of KSA_RUN
    n_done = 0;
    lat_init = 3; lat_ksa = 20; lat_prga = 3;
    key = 24'h123456; en = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (i == 1) en = 1'b0;
      if (i == 9) begin ksa_wren = 1'b1; ksa_addr = 8'h77; ksa_wrdata = 8'h3C; end
      if (i == 10) rst_n = 1'b0;
      #1;
      if (i == 9) begin
        chk("op3_mux_wren", s_wren, 1);
        chk("op3_mux_addr", s_addr, 8'h77);
        chk("op3_key", key_out, 24'h123456);
      end
      if (i == 10) begin
        chk("arst_rdy", rdy, 1); chk("arst_done", done, 0); chk("arst_err", err, 0);
        chk("arst_key_out", key_out, 0); chk("arst_s_wren", s_wren, 0);
        chk("arst_s_addr", s_addr, 0); chk("arst_s_wrdata", s_wrdata, 0);
        chk("arst_ens", {init_en, ksa_en, prga_en}, 0);
      end
    end
    ksa_wren = 1'b0; ksa_addr = '0; ksa_wrdata = '0;
    step(); step();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++) step();
    chk("op3_rdy_after_rst", rdy, 1);
    chk("op3_no_done", n_done, 0);
    $display("op3 key=%06h aborted by reset done_count=%0d", 24'h123456, n_done);

`ifdef ARC4_CTRL_WATCHDOG_EN
    // Watchdog: init never ready, err expected WDOG_CYCLES+1 cycles after accept
    begin
      int t_err;
      t_err = -1;
      init_hold = 1'b1;
      key = 24'h0000AA; en = 1'b1;
      for (int i = 1; i <= 5000 && t_err < 0; i++) begin
        step();
        if (i == 1) en = 1'b0;
        #1;
        if (err) t_err = i;
      end
      chk("wdog_err_cycle", t_err, 4097);
      chk("wdog_err_rdy", rdy, 1);
      init_hold = 1'b0;
      key = 24'h0000BB; en = 1'b1;
      step();
      en = 1'b0;
      #1;
      chk("wdog_err_clear", err, 0);
      chk("wdog_reissue_init_en", init_en, 1);
      chk("wdog_new_key", key_out, 24'h0000BB);
      $display("wdog key=%06h err_cycle=%0d", 24'h0000AA, t_err);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
